// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA fade/dither output stage.
package vga_pkg;

    // Global brightness fade controller states.
    typedef enum logic [1:0] {
        StHold    = 2'd0,
        StFadeIn  = 2'd1,
        StFadeOut = 2'd2
    } fade_state_e;

    // Full brightness: the scaler passes colour through unchanged.
    localparam logic [4:0] LEVEL_MAX = 5'd16;

    // 2x2 ordered-dither thresholds indexed by {y0,x0}: {0,2,3,1}.
    localparam logic [7:0] BAYER2X2 = {2'd1, 2'd3, 2'd2, 2'd0};

    // Bit positions on the TinyVGA PMOD output byte.
    localparam int unsigned PMOD_HSYNC = 7;
    localparam int unsigned PMOD_B0    = 6;
    localparam int unsigned PMOD_G0    = 5;
    localparam int unsigned PMOD_R0    = 4;
    localparam int unsigned PMOD_VSYNC = 3;
    localparam int unsigned PMOD_B1    = 2;
    localparam int unsigned PMOD_G1    = 1;
    localparam int unsigned PMOD_R1    = 0;

    function automatic logic [1:0] bayer_thresh(input logic y0, input logic x0);
        logic [2:0] base;
        base = {y0, x0, 1'b0};
        return BAYER2X2[base +: 2];
    endfunction

endpackage

// File: rtl/vga_dither_2b.sv
// One colour channel: brightness scale (S1), 2x2 ordered dither and blanking (S2).
module vga_dither_2b
    import vga_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] chan_i,
    input  logic [4:0] level_i,
    input  logic       de_s1_i,
    input  logic       x0_s1_i,
    input  logic       y0_s1_i,
    output logic [1:0] q_o
);

    logic [8:0] prod;
    logic [3:0] s_d, s_q;
    logic [1:0] q_d, q_q;
    logic [1:0] coarse, frac, thresh;

    // S1 scale: (c*level)>>4; the product never exceeds 240, so 4 bits hold the result.
    always_comb begin
        prod = {5'd0, chan_i} * {4'd0, level_i};
        s_d  = 4'(prod >> 4);
    end

    // S2 dither: round the 4-bit value up to the next 2-bit code where the fraction
    // beats the position threshold, saturating at 3; blank outside the visible area.
    always_comb begin
        coarse = s_q[3:2];
        frac   = s_q[1:0];
        thresh = bayer_thresh(y0_s1_i, x0_s1_i);
        q_d    = coarse;
        if (!de_s1_i) begin
            q_d = 2'd0;
        end else if ((frac > thresh) && (coarse != 2'd3)) begin
            q_d = coarse + 2'd1;
        end
    end

    // Pipeline registers for the scaled value and the dithered code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q <= '0;
            q_q <= '0;
        end else begin
            s_q <= s_d;
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/vga_fade_output.sv
// Final VGA stage: frame-synchronous fade, 2-bit dither per channel, sync re-alignment
// and PMOD packing.
module vga_fade_output
    import vga_pkg::*;
#(
    parameter int unsigned FRAMES_PER_STEP = 4,
    parameter bit          VSYNC_ACT_HIGH  = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        display_on,
    input  logic        pix_x0,
    input  logic        pix_y0,
    input  logic [11:0] rgb_in,
    input  logic        fade_req,
    input  logic        fade_in,
    output logic [7:0]  uo_out,
    output logic        frame_tick,
    output logic        fade_busy,
    output logic [4:0]  level
);

    localparam logic [7:0] DIV_LAST = 8'(FRAMES_PER_STEP - 1);

    logic        hs_s1_d, hs_s1_q, vs_s1_d, vs_s1_q;
    logic        de_s1_d, de_s1_q, x0_s1_d, x0_s1_q, y0_s1_d, y0_s1_q;
    logic        hs_s2_d, hs_s2_q, vs_s2_d, vs_s2_q;
    logic        tick_d, tick_q;
    fade_state_e state_d, state_q;
    logic [7:0]  div_d, div_q;
    logic [4:0]  level_d, level_q;
    logic [4:0]  target;
    logic [1:0]  r_q, g_q, b_q;

    // Sync delay line and S1 pixel-position copies; vs_s1_q doubles as the edge-detect sample.
    always_comb begin
        hs_s1_d = hsync_in;
        vs_s1_d = vsync_in;
        de_s1_d = display_on;
        x0_s1_d = pix_x0;
        y0_s1_d = pix_y0;
        hs_s2_d = hs_s1_q;
        vs_s2_d = vs_s1_q;
        tick_d  = (vsync_in == VSYNC_ACT_HIGH) && (vs_s1_q != VSYNC_ACT_HIGH);
    end

    // Fade controller: a request always wins over a coincident frame tick.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        level_d = level_q;
        target  = fade_in ? LEVEL_MAX : 5'd0;
        if (fade_req) begin
            div_d = '0;
            if (level_q == target) begin
                state_d = StHold;
            end else begin
                state_d = fade_in ? StFadeIn : StFadeOut;
            end
        end else if (tick_q) begin
            unique case (state_q)
                StFadeIn: begin
                    if (div_q == DIV_LAST) begin
                        div_d   = '0;
                        level_d = level_q + 5'd1;
                        if (level_d == LEVEL_MAX) begin
                            state_d = StHold;
                        end
                    end else begin
                        div_d = div_q + 8'd1;
                    end
                end
                StFadeOut: begin
                    if (div_q == DIV_LAST) begin
                        div_d   = '0;
                        level_d = level_q - 5'd1;
                        if (level_d == 5'd0) begin
                            state_d = StHold;
                        end
                    end else begin
                        div_d = div_q + 8'd1;
                    end
                end
                default: begin
                    state_d = StHold;
                end
            endcase
        end
    end

    // State, divider, level, edge-detect and sync pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_s1_q <= 1'b0;
            vs_s1_q <= 1'b0;
            de_s1_q <= 1'b0;
            x0_s1_q <= 1'b0;
            y0_s1_q <= 1'b0;
            hs_s2_q <= 1'b0;
            vs_s2_q <= 1'b0;
            tick_q  <= 1'b0;
            state_q <= StHold;
            div_q   <= '0;
            level_q <= '0;
        end else begin
            hs_s1_q <= hs_s1_d;
            vs_s1_q <= vs_s1_d;
            de_s1_q <= de_s1_d;
            x0_s1_q <= x0_s1_d;
            y0_s1_q <= y0_s1_d;
            hs_s2_q <= hs_s2_d;
            vs_s2_q <= vs_s2_d;
            tick_q  <= tick_d;
            state_q <= state_d;
            div_q   <= div_d;
            level_q <= level_d;
        end
    end

    vga_dither_2b u_dither_r (
        .clk     (clk),
        .rst_n   (rst_n),
        .chan_i  (rgb_in[11:8]),
        .level_i (level_q),
        .de_s1_i (de_s1_q),
        .x0_s1_i (x0_s1_q),
        .y0_s1_i (y0_s1_q),
        .q_o     (r_q)
    );

    vga_dither_2b u_dither_g (
        .clk     (clk),
        .rst_n   (rst_n),
        .chan_i  (rgb_in[7:4]),
        .level_i (level_q),
        .de_s1_i (de_s1_q),
        .x0_s1_i (x0_s1_q),
        .y0_s1_i (y0_s1_q),
        .q_o     (g_q)
    );

    vga_dither_2b u_dither_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .chan_i  (rgb_in[3:0]),
        .level_i (level_q),
        .de_s1_i (de_s1_q),
        .x0_s1_i (x0_s1_q),
        .y0_s1_i (y0_s1_q),
        .q_o     (b_q)
    );

    // PMOD byte packing.
    always_comb begin
        uo_out             = '0;
        uo_out[PMOD_HSYNC] = hs_s2_q;
        uo_out[PMOD_B0]    = b_q[0];
        uo_out[PMOD_G0]    = g_q[0];
        uo_out[PMOD_R0]    = r_q[0];
        uo_out[PMOD_VSYNC] = vs_s2_q;
        uo_out[PMOD_B1]    = b_q[1];
        uo_out[PMOD_G1]    = g_q[1];
        uo_out[PMOD_R1]    = r_q[1];
    end

    assign frame_tick = tick_q;
    assign fade_busy  = (state_q != StHold);
    assign level      = level_q;

endmodule

// File: tb/tb_vga_fade_output.sv
// Self-checking bench: two instances (1 and 3 frames per step) share timing/colour inputs
// and have independent fade controls.
module tb_vga_fade_output;

    logic        clk;
    logic        rst_n;
    logic        hsync_in, vsync_in, display_on, pix_x0, pix_y0;
    logic [11:0] rgb_in;
    logic        fade_req1, fade_in1, fade_req3, fade_in3;
    logic [7:0]  uo1, uo3;
    logic        tick1, tick3, busy1, busy3;
    logic [4:0]  lvl1, lvl3;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        hs;
        logic        vs;
        logic        de;
        logic        x0;
        logic        y0;
        logic [11:0] rgb;
        logic [7:0]  exp;
    } vec_t;

    vec_t tbl[9];
    logic [7:0] exp1_q[$];
    logic [7:0] exp3_q[$];

    vga_fade_output #(.FRAMES_PER_STEP(1), .VSYNC_ACT_HIGH(1'b0)) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .display_on (display_on),
        .pix_x0     (pix_x0),
        .pix_y0     (pix_y0),
        .rgb_in     (rgb_in),
        .fade_req   (fade_req1),
        .fade_in    (fade_in1),
        .uo_out     (uo1),
        .frame_tick (tick1),
        .fade_busy  (busy1),
        .level      (lvl1)
    );

    vga_fade_output #(.FRAMES_PER_STEP(3), .VSYNC_ACT_HIGH(1'b0)) u_dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .display_on (display_on),
        .pix_x0     (pix_x0),
        .pix_y0     (pix_y0),
        .rgb_in     (rgb_in),
        .fade_req   (fade_req3),
        .fade_in    (fade_in3),
        .uo_out     (uo3),
        .frame_tick (tick3),
        .fade_busy  (busy3),
        .level      (lvl3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: scale by level/16, split into 2-bit code + fraction, round up against
    // the ordered-dither threshold for the pixel position.
    function automatic logic [1:0] chan_ref(input int c, input int lvl, input logic x0,
                                            input logic y0, input logic de);
        int s, q, f, t;
        if (!de) return 2'd0;
        s = (c * lvl) / 16;
        q = s / 4;
        f = s % 4;
        case ({y0, x0})
            2'b00:   t = 0;
            2'b01:   t = 2;
            2'b10:   t = 3;
            default: t = 1;
        endcase
        if (f > t && q < 3) q = q + 1;
        return 2'(q);
    endfunction

    function automatic logic [7:0] uo_ref(input logic hs, input logic vs, input logic de,
                                          input logic x0, input logic y0,
                                          input logic [11:0] rgb, input int lvl);
        logic [1:0] r, g, b;
        r = chan_ref(int'(rgb[11:8]), lvl, x0, y0, de);
        g = chan_ref(int'(rgb[7:4]), lvl, x0, y0, de);
        b = chan_ref(int'(rgb[3:0]), lvl, x0, y0, de);
        return {hs, b[0], g[0], r[0], vs, b[1], g[1], r[1]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One frame: vsync goes active for two cycles; optionally pulse dut1's fade_req on
    // the cycle its frame_tick is high.
    task automatic frame(input bit req1, input bit dir1);
        vsync_in = 1'b0;
        step();
        chk("frame_tick", {31'd0, tick1}, 32'd1);
        if (req1) begin
            fade_req1 = 1'b1;
            fade_in1  = dir1;
        end
        step();
        fade_req1 = 1'b0;
        vsync_in  = 1'b1;
        step();
    endtask

    initial begin
        // hs vs de x0 y0 rgb exp (dut1 at level 16)
        tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'hFFF, 8'hFF};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'hFFF, 8'h08};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h600, 8'h89};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'h600, 8'h98};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 12'h600, 8'h98};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 12'h600, 8'h89};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h0F0, 8'h2A};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h005, 8'h8C};
        tbl[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 12'h888, 8'h0F};

        rst_n = 1'b0;
        hsync_in = 1'b0; vsync_in = 1'b1; display_on = 1'b0;
        pix_x0 = 1'b0; pix_y0 = 1'b0; rgb_in = 12'h000;
        fade_req1 = 1'b0; fade_in1 = 1'b0; fade_req3 = 1'b0; fade_in3 = 1'b0;

        // Outputs stay quiet under reset regardless of activity.
        for (int i = 0; i < 4; i++) begin
            hsync_in = 1'($urandom); vsync_in = 1'(i); display_on = 1'b1;
            rgb_in = 12'hFFF; fade_req1 = 1'b1; fade_in1 = 1'b1;
            step();
            chk("rst_uo1", {24'd0, uo1}, 32'd0);
            chk("rst_lvl1", {27'd0, lvl1}, 32'd0);
            chk("rst_busy1", {31'd0, busy1}, 32'd0);
            chk("rst_tick1", {31'd0, tick1}, 32'd0);
            chk("rst_uo3", {24'd0, uo3}, 32'd0);
        end
        rst_n = 1'b1; fade_req1 = 1'b0; fade_in1 = 1'b0;
        hsync_in = 1'b0; vsync_in = 1'b1; display_on = 1'b0;
        step(); step(); step();

        // Sync latency is two clocks.
        chk("sync_pre", {24'd0, uo1}, 32'h08);
        hsync_in = 1'b1; vsync_in = 1'b0;
        step();
        chk("sync_lat1", {24'd0, uo1}, 32'h08);
        step();
        chk("sync_lat2", {24'd0, uo1}, 32'h80);
        hsync_in = 1'b0; vsync_in = 1'b1;
        step(); step(); step();

        // Fade in on both instances.
        fade_req1 = 1'b1; fade_in1 = 1'b1; fade_req3 = 1'b1; fade_in3 = 1'b1;
        step();
        fade_req1 = 1'b0; fade_req3 = 1'b0;
        chk("fin_busy1", {31'd0, busy1}, 32'd1);
        chk("fin_busy3", {31'd0, busy3}, 32'd1);
        chk("fin_lvl1", {27'd0, lvl1}, 32'd0);
        for (int n = 1; n <= 16; n++) begin
            frame(1'b0, 1'b0);
            chk("fin_step_lvl1", {27'd0, lvl1}, 32'(n));
            chk("fin_step_busy1", {31'd0, busy1}, (n < 16) ? 32'd1 : 32'd0);
            chk("fin_step_lvl3", {27'd0, lvl3}, 32'(n / 3));
        end

        // Directed pixel vectors at full brightness.
        for (int i = 0; i < 9; i++) begin
            hsync_in = tbl[i].hs; vsync_in = tbl[i].vs; display_on = tbl[i].de;
            pix_x0 = tbl[i].x0; pix_y0 = tbl[i].y0; rgb_in = tbl[i].rgb;
            step(); step();
            chk($sformatf("tbl_%0d", i), {24'd0, uo1}, {24'd0, tbl[i].exp});
        end

        // Random pixel stream, vsync held inactive so levels stay at 16 and 5.
        vsync_in = 1'b1;
        for (int i = 0; i < 200; i++) begin
            hsync_in = 1'($urandom); display_on = 1'($urandom_range(0, 3) != 0);
            pix_x0 = 1'($urandom); pix_y0 = 1'($urandom); rgb_in = 12'($urandom);
            exp1_q.push_back(uo_ref(hsync_in, 1'b1, display_on, pix_x0, pix_y0, rgb_in, 16));
            exp3_q.push_back(uo_ref(hsync_in, 1'b1, display_on, pix_x0, pix_y0, rgb_in, 5));
            step();
            if (i >= 1) begin
                chk("rand_uo1", {24'd0, uo1}, {24'd0, exp1_q.pop_front()});
                chk("rand_uo3", {24'd0, uo3}, {24'd0, exp3_q.pop_front()});
            end
        end
        exp1_q.delete(); exp3_q.delete();
        hsync_in = 1'b0; display_on = 1'b0;

        // Continue the slow fade to level 9.
        for (int n = 17; n <= 27; n++) begin
            frame(1'b0, 1'b0);
            chk("fin3_lvl3", {27'd0, lvl3}, 32'(n / 3));
            chk("hold_lvl1", {27'd0, lvl1}, 32'd16);
        end

        // Retarget to fade-out at level 9: divider restarts, then down to 0.
        fade_req3 = 1'b1; fade_in3 = 1'b0;
        step();
        fade_req3 = 1'b0;
        chk("retgt_busy3", {31'd0, busy3}, 32'd1);
        chk("retgt_lvl3", {27'd0, lvl3}, 32'd9);
        for (int k = 1; k <= 27; k++) begin
            frame(1'b0, 1'b0);
            chk("fout_lvl3", {27'd0, lvl3}, 32'(9 - k / 3));
            chk("fout_busy3", {31'd0, busy3}, (k < 27) ? 32'd1 : 32'd0);
        end

        // Requests on tick cycles: the coincident tick is not counted.
        frame(1'b1, 1'b0);
        chk("tickreq_lvl1", {27'd0, lvl1}, 32'd16);
        chk("tickreq_busy1", {31'd0, busy1}, 32'd1);
        frame(1'b0, 1'b0);
        chk("fout_lvl1_15", {27'd0, lvl1}, 32'd15);
        frame(1'b0, 1'b0);
        chk("fout_lvl1_14", {27'd0, lvl1}, 32'd14);
        frame(1'b1, 1'b0);
        chk("tickreq_hold14", {27'd0, lvl1}, 32'd14);
        frame(1'b0, 1'b0);
        chk("fout_lvl1_13", {27'd0, lvl1}, 32'd13);

        // Mid-operation reset with a visible pixel in flight.
        hsync_in = 1'b1; display_on = 1'b1; rgb_in = 12'hFFF; pix_x0 = 1'b0; pix_y0 = 1'b0;
        step(); step();
        chk("pre_rst_uo1", {24'd0, uo1},
            {24'd0, uo_ref(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'hFFF, 13)});
        rst_n = 1'b0;
        #1;
        chk("midrst_uo1", {24'd0, uo1}, 32'd0);
        chk("midrst_lvl1", {27'd0, lvl1}, 32'd0);
        chk("midrst_busy1", {31'd0, busy1}, 32'd0);
        step(); step();
        chk("midrst_uo1_hold", {24'd0, uo1}, 32'd0);
        chk("midrst_tick1", {31'd0, tick1}, 32'd0);
        rst_n = 1'b1; hsync_in = 1'b0; display_on = 1'b0;
        step();

        // Fade-out request at level 0 is already on target.
        fade_req1 = 1'b1; fade_in1 = 1'b0;
        step();
        fade_req1 = 1'b0;
        chk("noop_busy1", {31'd0, busy1}, 32'd0);
        chk("noop_lvl1", {27'd0, lvl1}, 32'd0);
        fade_req1 = 1'b1; fade_in1 = 1'b1;
        step();
        fade_req1 = 1'b0;
        chk("restart_busy1", {31'd0, busy1}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
